cic_interp_iq: RTL and testbench
================================

Name: cic_interp_iq

Overview:
- Final upsampling stage of the transmit chain. Sits directly downstream of the halfband interpolator.
- Takes I/Q samples at the halfband output rate (strobe_in) and interpolates them by a runtime ratio `rate` to the DAC-side strobe_out rate.
- Structure: N-stage cascaded integrator-comb (CIC) with zero-stuffing, M = 1.
- Scales the bit growth of R^(N-1) back to 16 bits with a rate-dependent shift.

Parameters:
- bw, 16, input/output sample width, two's complement.
- N, 4, number of comb stages and number of integrator stages.
- log2_of_max_rate, 7, maximum supported ratio is 2^7 = 128.
- iw, bw+(N-1)*log2_of_max_rate, internal accumulator width (37 at defaults).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  when low, all state is held at zero, same as reset.
- rate  in  8  interpolation ratio R. Legal range 1..128. Sampled continuously; change it only while enable is low.
- strobe_in  in  1  one-cycle pulse, input sample valid (halfband output rate).
- strobe_out  in  1  one-cycle pulse, output sample rate. Exactly R strobe_out pulses per strobe_in period.
- signal_in_i  in  bw  input I sample.
- signal_in_q  in  bw  input Q sample.
- signal_out_i  out  bw  output I sample, registered.
- signal_out_q  out  bw  output Q sample, registered.

Behaviour:
- Reset/enable:
  - When reset=1 or enable=0 at a clock edge, every comb register, comb delay, integrator, the pending flag and both outputs clear to 0 on that edge.
  - This also applies mid-operation; no partial state survives.
- I and Q datapaths are identical and share all control.
- Input is sign-extended to iw bits.
- Combs (update only on strobe_in), stage k = 0..N-1:
  - comb[k] <= cin[k] - dly[k]
  - dly[k] <= cin[k]
  - cin[0] = extended input; cin[k] = comb[k-1] (registered).
  - The comb section is therefore N strobe_in periods deep.
- Zero-stuff control:
  - pending <= 1 on strobe_in; pending <= 0 on strobe_out.
  - If both fire in the same cycle, pending ends at 1.
  - The comb value written in that cycle is consumed by the next strobe_out, not the coincident one.
- Integrators (update only on strobe_out):
  - int[0] <= int[0] + (pending ? comb[N-1] : 0)
  - int[k] <= int[k] + int[k-1] for k ≥ 1, using the pre-edge value of int[k-1].
- Arithmetic: all arithmetic is modulo 2^iw, with wrap-around permitted. CIC wrap is self-cancelling and must not saturate.
- Gain and scaling:
  - Gain is R^(N-1).
  - shift = (N-1)*ceil(log2(R)); R=1 gives shift 0, R=128 gives shift 21.
  - On strobe_out: signal_out <= int[N-1][shift+bw-1 : shift], truncated with no rounding.
  - Power-of-two R gives unity DC gain.
  - Other R gives DC gain R^(N-1)/2^shift < 1. Example: R=5 gives 125/512.
  - No output overflow is possible for legal R.
- Outputs hold their value between strobe_out pulses.
- Latency: a single nonzero input first affects the output no later than N strobe_in periods plus N+1 strobe_out pulses after its strobe_in. The latency is fixed for a given R.
- Strobe rules:
  - strobe_in with no strobe_out between: the earlier comb sample is overwritten in the integrator feed, and pending stays 1.
  - strobe_out with no preceding strobe_in: zero is injected.
  - Neither case is a legal operating mode, but both are deterministic as stated.
- rate=0 is illegal. The block must treat it as R=1 (shift 0).

Test Plan:
- Reset/enable clear: run with R=8, N=4 and nonzero data, then assert reset for 1 cycle → next cycle all outputs 0, and output stays 0 with zero input. Repeat with enable=0.
- DC, power of two: R=8, strobe_out every cycle, strobe_in every 8th, I=+1000 and Q=-1000 constant → after settling, every output sample is exactly I=1000, Q=-1000.
- Bypass: R=1, strobe_in=strobe_out every 2nd cycle, ramp input 0,1,2,... → output is the same ramp, delayed by a constant number of strobes.
- Full scale at max rate: R=128, I=+32767, Q=-32768 constant → steady output 32767 / -32768 with no overflow or sign flip. Internal integrators wrap without error.
- Non-power-of-two: R=5, I=+1024 constant → steady output 250 (1024*125/512).
- Impulse: R=4, a single input I=512 then zeros → output matches a golden zero-stuffed CIC model sample for sample, including latency, and returns to exactly 0 afterwards.

Source files
------------

// File: rtl/cic_interp_iq_if.sv
// Sample-stream bundle for the interpolating CIC: strobes plus I/Q in/out samples.
// The master drives strobes and input samples; the slave (the filter) drives the outputs.
interface cic_interp_iq_if #(
  parameter int unsigned bw = 16
);
  logic          strobe_in;
  logic          strobe_out;
  logic [bw-1:0] signal_in_i;
  logic [bw-1:0] signal_in_q;
  logic [bw-1:0] signal_out_i;
  logic [bw-1:0] signal_out_q;

  modport master (
    output strobe_in,
    output strobe_out,
    output signal_in_i,
    output signal_in_q,
    input  signal_out_i,
    input  signal_out_q
  );

  modport slave (
    input  strobe_in,
    input  strobe_out,
    input  signal_in_i,
    input  signal_in_q,
    output signal_out_i,
    output signal_out_q
  );
endinterface

// File: rtl/cic_interp_iq.sv
// N-stage zero-stuffing CIC interpolator (M = 1) for an I/Q pair, runtime ratio 1..128,
// with a rate-dependent shift that removes R^(N-1) bit growth.
module cic_interp_iq #(
  parameter int unsigned bw               = 16,
  parameter int unsigned N                = 4,
  parameter int unsigned log2_of_max_rate = 7,
  parameter int unsigned iw               = bw + (N - 1) * log2_of_max_rate
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic [7:0]     rate,
  cic_interp_iq_if.slave bus
);

  logic [iw-1:0] comb_q [2][N];
  logic [iw-1:0] dly_q  [2][N];
  logic [iw-1:0] int_q  [2][N];
  logic [iw-1:0] cin    [2][N];
  logic [iw-1:0] feed   [2][N];
  logic [bw-1:0] out_q  [2];
  logic [bw-1:0] out_sel[2];
  logic          pending_q;

  logic [7:0]  rate_m1;
  int unsigned clog;
  int unsigned shift;

  // ceil(log2(R)) is the bit length of R-1; rate 0 behaves as R = 1.
  always_comb begin
    rate_m1 = (rate == 8'd0) ? 8'd0 : rate - 8'd1;
    clog    = 0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (rate_m1[b]) clog = b + 1;
    end
    if (clog > log2_of_max_rate) clog = log2_of_max_rate;
    shift = (N - 1) * clog;
  end

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      cin[c][0]  = (c == 0) ? {{(iw - bw){bus.signal_in_i[bw-1]}}, bus.signal_in_i}
                            : {{(iw - bw){bus.signal_in_q[bw-1]}}, bus.signal_in_q};
      feed[c][0] = pending_q ? comb_q[c][N-1] : '0;
      for (int unsigned k = 1; k < N; k++) begin
        cin[c][k]  = comb_q[c][k-1];
        feed[c][k] = int_q[c][k-1];
      end
      out_sel[c] = bw'(int_q[c][N-1] >> shift);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      pending_q <= 1'b0;
      for (int unsigned c = 0; c < 2; c++) begin
        out_q[c] <= '0;
        for (int unsigned k = 0; k < N; k++) begin
          comb_q[c][k] <= '0;
          dly_q[c][k]  <= '0;
          int_q[c][k]  <= '0;
        end
      end
    end else begin
      // A coincident strobe_in wins, so its fresh comb value feeds the next strobe_out.
      if (bus.strobe_in) begin
        pending_q <= 1'b1;
      end else if (bus.strobe_out) begin
        pending_q <= 1'b0;
      end
      for (int unsigned c = 0; c < 2; c++) begin
        if (bus.strobe_in) begin
          for (int unsigned k = 0; k < N; k++) begin
            comb_q[c][k] <= cin[c][k] - dly_q[c][k];
            dly_q[c][k]  <= cin[c][k];
          end
        end
        if (bus.strobe_out) begin
          for (int unsigned k = 0; k < N; k++) begin
            int_q[c][k] <= int_q[c][k] + feed[c][k];
          end
          out_q[c] <= out_sel[c];
        end
      end
    end
  end

  assign bus.signal_out_i = out_q[0];
  assign bus.signal_out_q = out_q[1];

endmodule

// File: tb/tb_cic_interp_iq.sv
// Bench for cic_interp_iq: golden zero-stuffed CIC model feeding a scoreboard, plus
// directed steady-state, bypass-ramp and reset/enable clear checks.
module tb_cic_interp_iq;

  localparam int unsigned Bw = 16;
  localparam int unsigned Iw = 37;
  localparam longint unsigned Mask = (64'd1 << Iw) - 64'd1;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] rate;
  string      phase;
  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb[$];

  longint unsigned m_comb[2][4];
  longint unsigned m_dly [2][4];
  longint unsigned m_int [2][4];
  int              m_out [2];
  logic            m_pend;

  cic_interp_iq_if #(.bw(Bw)) bus ();

  cic_interp_iq #(
    .bw               (Bw),
    .N                (4),
    .log2_of_max_rate (7)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .rate   (rate),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_i();
    logic signed [15:0] t;
    t = bus.signal_out_i;
    return int'(t);
  endfunction

  function automatic int dut_q();
    logic signed [15:0] t;
    t = bus.signal_out_q;
    return int'(t);
  endfunction

  // Golden model of one clock edge, evaluated from pre-edge state.
  task automatic model_edge(input logic si, input logic so);
    longint          s;
    longint unsigned ext[2];
    longint unsigned cin, o;
    int unsigned     r, p, sh;
    logic signed [15:0] t;
    if (reset || !enable) begin
      m_pend = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_out[c] = 0;
        for (int k = 0; k < 4; k++) begin
          m_comb[c][k] = 0;
          m_dly[c][k]  = 0;
          m_int[c][k]  = 0;
        end
      end
      return;
    end
    s = $signed(bus.signal_in_i);
    ext[0] = s;
    ext[0] &= Mask;
    s = $signed(bus.signal_in_q);
    ext[1] = s;
    ext[1] &= Mask;
    r = (rate == 8'd0) ? 1 : int'(rate);
    p = 0;
    while ((1 << p) < r) p++;
    sh = 3 * p;
    for (int c = 0; c < 2; c++) begin
      if (so) begin
        o = (m_int[c][3] >> sh) & 64'hFFFF;
        t = o[15:0];
        m_out[c] = int'(t);
        for (int k = 3; k >= 1; k--) m_int[c][k] = (m_int[c][k] + m_int[c][k-1]) & Mask;
        m_int[c][0] = (m_int[c][0] + (m_pend ? m_comb[c][3] : 64'd0)) & Mask;
      end
      if (si) begin
        for (int k = 3; k >= 0; k--) begin
          cin = (k == 0) ? ext[c] : m_comb[c][k-1];
          m_comb[c][k] = (cin - m_dly[c][k]) & Mask;
          m_dly[c][k]  = cin;
        end
      end
    end
    if (si) m_pend = 1'b1;
    else if (so) m_pend = 1'b0;
  endtask

  task automatic tick(input logic si, input logic so);
    exp_t e;
    logic live;
    bus.strobe_in  = si;
    bus.strobe_out = so;
    live = so && !reset && enable;
    @(posedge clock);
    model_edge(si, so);
    if (live) sb.push_back('{i: m_out[0], q: m_out[1]});
    #1;
    bus.strobe_in  = 1'b0;
    bus.strobe_out = 1'b0;
    if (live && sb.size() > 0) begin
      e = sb.pop_front();
      check({phase, "_model_i"}, dut_i(), e.i);
      check({phase, "_model_q"}, dut_q(), e.q);
    end
  endtask

  // n output strobes, strobe_in on every r-th, gap-1 idle cycles after each.
  task automatic run(input int r, input int n, input int gap);
    for (int j = 0; j < n; j++) begin
      tick(j % r == 0, 1'b1);
      for (int g = 1; g < gap; g++) tick(1'b0, 1'b0);
    end
  endtask

  task automatic run_check(input int r, input int n, input int ei, input int eq);
    for (int j = 0; j < n; j++) begin
      tick(j % r == 0, 1'b1);
      check({phase, "_i"}, dut_i(), ei);
      check({phase, "_q"}, dut_q(), eq);
    end
  endtask

  task automatic set_rate(input logic [7:0] r);
    enable = 1'b0;
    tick(1'b0, 1'b0);
    rate   = r;
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    rate = 8'd8;
    bus.strobe_in = 1'b0;
    bus.strobe_out = 1'b0;
    bus.signal_in_i = '0;
    bus.signal_in_q = '0;
    phase = "reset";
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("reset_i", dut_i(), 0);
    check("reset_q", dut_q(), 0);
    reset = 1'b0;

    phase = "dc8";
    bus.signal_in_i = 16'sd1000;
    bus.signal_in_q = -16'sd1000;
    run(8, 80, 1);
    run_check(8, 32, 1000, -1000);

    phase = "rst_mid";
    reset = 1'b1;
    tick(1'b0, 1'b1);
    check("rst_mid_i", dut_i(), 0);
    check("rst_mid_q", dut_q(), 0);
    reset = 1'b0;
    bus.signal_in_i = '0;
    bus.signal_in_q = '0;
    run_check(8, 24, 0, 0);

    phase = "en_mid";
    bus.signal_in_i = 16'sd1000;
    bus.signal_in_q = -16'sd1000;
    run(8, 48, 1);
    enable = 1'b0;
    tick(1'b1, 1'b1);
    check("en_mid_i", dut_i(), 0);
    check("en_mid_q", dut_q(), 0);
    enable = 1'b1;
    bus.signal_in_i = '0;
    bus.signal_in_q = '0;
    run_check(8, 24, 0, 0);

    // R=1: the output is the input ramp delayed by eight strobes.
    phase = "bypass";
    set_rate(8'd1);
    for (int n = 0; n < 40; n++) begin
      bus.signal_in_i = 16'(n);
      bus.signal_in_q = 16'(-n);
      tick(1'b1, 1'b1);
      check("bypass_i", dut_i(), (n >= 8) ? n - 8 : 0);
      check("bypass_q", dut_q(), (n >= 8) ? 8 - n : 0);
      tick(1'b0, 1'b0);
    end

    phase = "rate0";
    set_rate(8'd0);
    bus.signal_in_i = 16'sd77;
    bus.signal_in_q = -16'sd77;
    run(1, 12, 2);
    run_check(1, 6, 77, -77);

    phase = "fs128";
    set_rate(8'd128);
    bus.signal_in_i = 16'sd32767;
    bus.signal_in_q = -16'sd32768;
    run(128, 128 * 8, 1);
    run_check(128, 256, 32767, -32768);

    phase = "r5";
    set_rate(8'd5);
    bus.signal_in_i = 16'sd1024;
    bus.signal_in_q = -16'sd1024;
    run(5, 50, 1);
    run_check(5, 40, 250, -250);

    phase = "impulse";
    set_rate(8'd4);
    bus.signal_in_i = 16'sd512;
    bus.signal_in_q = 16'sd0;
    tick(1'b1, 1'b1);
    bus.signal_in_i = '0;
    for (int j = 1; j < 48; j++) tick(j % 4 == 0, 1'b1);
    run_check(4, 16, 0, 0);

    // Irregular strobes exercise the overwrite and zero-injection rules.
    phase = "irregular";
    for (int j = 0; j < 200; j++) begin
      bus.signal_in_i = 16'($urandom_range(0, 65535));
      bus.signal_in_q = 16'($urandom_range(0, 65535));
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
